// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for an RV32 datapath: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
// Optional performance counters (retired, cycles) are built only when MC_CTRL_PERF_EN is defined.
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [31:0]      ins_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic             reg_write_o,
    output logic             alu_src_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             mem2reg_o,
    output logic             link_o,
    output logic             branch_o,
    output logic             jump_o,
    output logic [2:0]       op_o,
    output logic [2:0]       state_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] retired_o,
    output logic [CNT_W-1:0] cycles_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXECUTE = 3'd3,
        S_MEMORY = 3'd4, S_WRITEBACK = 3'd5, S_HALT = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_NONE = 3'd0, C_R = 3'd1, C_I = 3'd2, C_LW = 3'd3,
        C_SW = 3'd4, C_BEQ = 3'd5, C_JAL = 3'd6
    } cls_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    state_t     state_q, state_d;
    cls_t       cls_q, cls_d;
    logic [2:0] op_q, op_d;
    cls_t       dec_cls;
    logic [2:0] dec_op;
    logic       dec_ok;
    logic       alu_f3_ok;
    logic [2:0] alu_f3_op;
    logic       retire;
    logic       unused_ins;

    assign unused_ins = ^{ins_i[31], ins_i[29:15], ins_i[11:7]};

    // ALU operation from funct3; ins[30] selects sub only for R-type.
    always_comb begin
        alu_f3_ok = 1'b1;
        alu_f3_op = OP_ADD;
        unique case (ins_i[14:12])
            3'b000:  alu_f3_op = (ins_i[30] && ins_i[6:0] == 7'b0110011) ? OP_SUB : OP_ADD;
            3'b111:  alu_f3_op = OP_AND;
            3'b110:  alu_f3_op = OP_OR;
            3'b010:  alu_f3_op = OP_SLT;
            default: alu_f3_ok = 1'b0;
        endcase
    end

    // Instruction class decode from the opcode.
    always_comb begin
        dec_cls = C_NONE;
        dec_op  = OP_ADD;
        dec_ok  = 1'b1;
        unique case (ins_i[6:0])
            7'b0110011: begin dec_cls = C_R;   dec_op = alu_f3_op; dec_ok = alu_f3_ok; end
            7'b0010011: begin dec_cls = C_I;   dec_op = alu_f3_op; dec_ok = alu_f3_ok; end
            7'b0000011: dec_cls = C_LW;
            7'b0100011: dec_cls = C_SW;
            7'b1100011: begin dec_cls = C_BEQ; dec_op = OP_SUB; dec_ok = (ins_i[14:12] == 3'b000); end
            7'b1101111: dec_cls = C_JAL;
            default:    dec_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cls_q   <= C_NONE;
            op_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            op_q    <= op_d;
        end
    end

    // Next-state and control strobes, combinational from state and latched class.
    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        op_d        = op_q;
        retire      = 1'b0;
        ir_we_o     = 1'b0;
        pc_we_o     = 1'b0;
        reg_write_o = 1'b0;
        alu_src_o   = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem2reg_o   = 1'b0;
        link_o      = 1'b0;
        branch_o    = 1'b0;
        jump_o      = 1'b0;
        op_o        = 3'b000;
        unique case (state_q)
            S_IDLE: if (start_i) state_d = S_FETCH;
            S_FETCH: begin
                mem_read_o = 1'b1;
                if (mem_ready_i) begin
                    ir_we_o = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_ok) begin
                    cls_d   = dec_cls;
                    op_d    = dec_op;
                    state_d = S_EXECUTE;
                end else begin
                    cls_d   = C_NONE;
                    state_d = S_HALT;
                end
            end
            S_EXECUTE: begin
                op_o      = op_q;
                alu_src_o = (cls_q == C_I) || (cls_q == C_LW) || (cls_q == C_SW);
                if (cls_q == C_BEQ) begin
                    branch_o = zero_i;
                    pc_we_o  = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else if (cls_q == C_LW || cls_q == C_SW) begin
                    state_d = S_MEMORY;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                op_o        = OP_ADD;
                alu_src_o   = 1'b1;
                mem_read_o  = (cls_q == C_LW);
                mem_write_o = (cls_q == C_SW);
                if (mem_ready_i) begin
                    if (cls_q == C_SW) begin
                        pc_we_o = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                reg_write_o = 1'b1;
                pc_we_o     = 1'b1;
                retire      = 1'b1;
                mem2reg_o   = (cls_q == C_LW);
                jump_o      = (cls_q == C_JAL);
                link_o      = (cls_q == C_JAL);
                op_o        = (cls_q == C_R || cls_q == C_I) ? op_q : 3'b000;
                state_d     = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    assign state_o   = state_q;
    assign illegal_o = (state_q == S_HALT);

`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] retired_q, cycles_q;

    // Free-running counters; both wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            cycles_q  <= '0;
        end else begin
            if (retire) retired_q <= retired_q + CNT_W'(1);
            if (state_q != S_IDLE && state_q != S_HALT) cycles_q <= cycles_q + CNT_W'(1);
        end
    end

    assign retired_o = retired_q;
    assign cycles_o  = cycles_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign retired_o     = '0;
    assign cycles_o      = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; counter expectations follow MC_CTRL_PERF_EN.
module tb_multicycle_ctrl;

`ifdef MC_CTRL_PERF_EN
    localparam bit          PERF  = 1'b1;
    localparam int unsigned CNT_W = 4;
`else
    localparam bit          PERF  = 1'b0;
    localparam int unsigned CNT_W = 32;
`endif
    // Observation vector: {state[2:0], op[2:0], ir_we, pc_we, reg_write, alu_src,
    //                      mem_read, mem_write, mem2reg, link, branch, jump}
    localparam logic [15:0] M_ALL = 16'hFFFF;
    localparam logic [15:0] M_NOP = 16'hE3FF;

    logic             clk, rst_n, start_i, zero_i, mem_ready_i;
    logic [31:0]      ins_i;
    logic             ir_we_o, pc_we_o, reg_write_o, alu_src_o, mem_read_o, mem_write_o;
    logic             mem2reg_o, link_o, branch_o, jump_o, illegal_o;
    logic [2:0]       op_o, state_o;
    logic [CNT_W-1:0] retired_o, cycles_o;
    logic [15:0]      obs;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .ins_i(ins_i), .zero_i(zero_i),
        .mem_ready_i(mem_ready_i), .ir_we_o(ir_we_o), .pc_we_o(pc_we_o),
        .reg_write_o(reg_write_o), .alu_src_o(alu_src_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .mem2reg_o(mem2reg_o), .link_o(link_o),
        .branch_o(branch_o), .jump_o(jump_o), .op_o(op_o), .state_o(state_o),
        .illegal_o(illegal_o), .retired_o(retired_o), .cycles_o(cycles_o)
    );

    assign obs = {state_o, op_o, ir_we_o, pc_we_o, reg_write_o, alu_src_o,
                  mem_read_o, mem_write_o, mem2reg_o, link_o, branch_o, jump_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CNT_W-1:0] cexp(input int unsigned v);
        return PERF ? CNT_W'(v) : '0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b1; start_i = 1'b0; zero_i = 1'b0; mem_ready_i = 1'b0; ins_i = '1;
        #1 rst_n = 1'b0;
        #1;
        n_tests++; if (obs !== 16'h0) begin n_fail++; $display("FAIL reset_obs got=%h exp=0000", obs); end
        n_tests++; if (illegal_o !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got=%b exp=0", illegal_o); end
        n_tests++; if (retired_o !== '0) begin n_fail++; $display("FAIL reset_retired got=%0d exp=0", retired_o); end
        n_tests++; if (cycles_o !== '0) begin n_fail++; $display("FAIL reset_cycles got=%0d exp=0", cycles_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [15:0] ex [4];
        logic [15:0] mk [4];
        ex = '{{3'd1, 3'b000, 10'b1000100000}, {3'd2, 3'b000, 10'b0},
               {3'd3, 3'b010, 10'b0},          {3'd5, 3'b010, 10'b0110000000}};
        mk = '{M_NOP, M_NOP, M_ALL, M_ALL};
        start_i = 1'b1; mem_ready_i = 1'b1;
        #1;
        n_tests++; if (obs !== 16'h0) begin n_fail++; $display("FAIL add_idle got=%h exp=0000", obs); end
        @(posedge clk); @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ins_i = (i == 1) ? 32'h002081B3 : 32'hFFFF_FFFF;
            mem_ready_i = 1'b1;
            #1;
            n_tests++;
            if ((obs & mk[i]) !== ex[i]) begin
                n_fail++; $display("FAIL add_c%0d got=%h exp=%h", i, obs & mk[i], ex[i]);
            end
            @(posedge clk); @(negedge clk);
        end
        n_tests++; if (retired_o !== cexp(1)) begin n_fail++; $display("FAIL add_retired got=%0d exp=%0d", retired_o, cexp(1)); end
        n_tests++; if (cycles_o !== cexp(4)) begin n_fail++; $display("FAIL add_cycles got=%0d exp=%0d", cycles_o, cexp(4)); end
    endtask

    task automatic test_lw_stall();
        logic [15:0] ex [7];
        logic [15:0] mk [7];
        logic        mr [7];
        ex = '{{3'd1, 3'b000, 10'b1000100000}, {3'd2, 3'b000, 10'b0},
               {3'd3, 3'b010, 10'b0001000000}, {3'd4, 3'b010, 10'b0001100000},
               {3'd4, 3'b010, 10'b0001100000}, {3'd4, 3'b010, 10'b0001100000},
               {3'd5, 3'b000, 10'b0110001000}};
        mk = '{M_NOP, M_NOP, M_ALL, M_ALL, M_ALL, M_ALL, M_NOP};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            ins_i = (i == 1) ? 32'h0000A183 : 32'hFFFF_FFFF;
            mem_ready_i = mr[i];
            #1;
            n_tests++;
            if ((obs & mk[i]) !== ex[i]) begin
                n_fail++; $display("FAIL lw_c%0d got=%h exp=%h", i, obs & mk[i], ex[i]);
            end
            @(posedge clk); @(negedge clk);
        end
        n_tests++; if (retired_o !== cexp(2)) begin n_fail++; $display("FAIL lw_retired got=%0d exp=%0d", retired_o, cexp(2)); end
        n_tests++; if (cycles_o !== cexp(11)) begin n_fail++; $display("FAIL lw_cycles got=%0d exp=%0d", cycles_o, cexp(11)); end
    endtask

    task automatic test_beq();
        logic [15:0] ex [3];
        logic [15:0] mk [3];
        mk = '{M_NOP, M_NOP, M_ALL};
        for (int z = 1; z >= 0; z--) begin
            ex = '{{3'd1, 3'b000, 10'b1000100000}, {3'd2, 3'b000, 10'b0},
                   {3'd3, 3'b110, 8'b01000000, z[0], 1'b0}};
            for (int i = 0; i < 3; i++) begin
                ins_i = (i == 1) ? 32'h00208463 : 32'hFFFF_FFFF;
                mem_ready_i = 1'b1;
                zero_i = z[0];
                #1;
                n_tests++;
                if ((obs & mk[i]) !== ex[i]) begin
                    n_fail++; $display("FAIL beq_z%0d_c%0d got=%h exp=%h", z, i, obs & mk[i], ex[i]);
                end
                @(posedge clk); @(negedge clk);
            end
            n_tests++;
            if (retired_o !== cexp(unsigned'(4 - z))) begin
                n_fail++; $display("FAIL beq_z%0d_retired got=%0d exp=%0d", z, retired_o, cexp(unsigned'(4 - z)));
            end
        end
        zero_i = 1'b0;
        n_tests++; if (cycles_o !== cexp(17)) begin n_fail++; $display("FAIL beq_cycles got=%0d exp=%0d", cycles_o, cexp(17)); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ex [5];
        logic [15:0] mk [5];
        logic        mr [5];
        // SW with one fetch stall.
        ex = '{{3'd1, 3'b000, 10'b0000100000}, {3'd1, 3'b000, 10'b1000100000},
               {3'd2, 3'b000, 10'b0},          {3'd3, 3'b010, 10'b0001000000},
               {3'd4, 3'b010, 10'b0101010000}};
        mk = '{M_NOP, M_NOP, M_NOP, M_ALL, M_ALL};
        mr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            ins_i = (i == 2) ? 32'h0020A023 : 32'hFFFF_FFFF;
            mem_ready_i = mr[i];
            #1;
            n_tests++;
            if ((obs & mk[i]) !== ex[i]) begin
                n_fail++; $display("FAIL sw_c%0d got=%h exp=%h", i, obs & mk[i], ex[i]);
            end
            @(posedge clk); @(negedge clk);
        end
        n_tests++; if (retired_o !== cexp(5)) begin n_fail++; $display("FAIL sw_retired got=%0d exp=%0d", retired_o, cexp(5)); end
        // JAL right behind it.
        ex = '{{3'd1, 3'b000, 10'b1000100000}, {3'd2, 3'b000, 10'b0},
               {3'd3, 3'b000, 10'b0},          {3'd5, 3'b000, 10'b0110000101}, 16'h0};
        mk = '{M_NOP, M_NOP, M_NOP, M_NOP, M_ALL};
        for (int i = 0; i < 4; i++) begin
            ins_i = (i == 1) ? 32'h008000EF : 32'hFFFF_FFFF;
            mem_ready_i = 1'b1;
            #1;
            n_tests++;
            if ((obs & mk[i]) !== ex[i]) begin
                n_fail++; $display("FAIL jal_c%0d got=%h exp=%h", i, obs & mk[i], ex[i]);
            end
            @(posedge clk); @(negedge clk);
        end
        n_tests++; if (retired_o !== cexp(6)) begin n_fail++; $display("FAIL jal_retired got=%0d exp=%0d", retired_o, cexp(6)); end
        n_tests++; if (cycles_o !== cexp(26)) begin n_fail++; $display("FAIL jal_cycles got=%0d exp=%0d", cycles_o, cexp(26)); end
    endtask

    task automatic test_illegal();
        mem_ready_i = 1'b1;
        ins_i = 32'hFFFF_FFFF;
        @(posedge clk); @(negedge clk);
        ins_i = 32'h0000007F;
        #1;
        n_tests++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL ill_decode got=%0d exp=2", state_o); end
        @(posedge clk); @(negedge clk);
        ins_i = 32'h002081B3;
        for (int i = 0; i < 3; i++) begin
            start_i = 1'b1;
            #1;
            n_tests++;
            if (obs !== {3'd7, 13'h0} || illegal_o !== 1'b1) begin
                n_fail++; $display("FAIL halt_c%0d got=%h/%b exp=e000/1", i, obs, illegal_o);
            end
            @(posedge clk); @(negedge clk);
        end
        n_tests++; if (cycles_o !== cexp(28 % 16)) begin n_fail++; $display("FAIL halt_cycles got=%0d exp=%0d", cycles_o, cexp(28 % 16)); end
        n_tests++; if (retired_o !== cexp(6)) begin n_fail++; $display("FAIL halt_retired got=%0d exp=%0d", retired_o, cexp(6)); end
        start_i = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (state_o !== 3'd0 || illegal_o !== 1'b0 || obs !== 16'h0) begin
            n_fail++; $display("FAIL async_reset got=%h/%b exp=0000/0", obs, illegal_o);
        end
        n_tests++;
        if (retired_o !== '0 || cycles_o !== '0) begin
            n_fail++; $display("FAIL async_reset_cnt got=%0d/%0d exp=0/0", retired_o, cycles_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_counter_wrap();
        start_i = 1'b1; mem_ready_i = 1'b1;
        @(posedge clk); @(negedge clk);
        start_i = 1'b0;
        for (int n = 0; n < 17; n++) begin
            for (int i = 0; i < 3; i++) begin
                ins_i = (i == 1) ? 32'h00208463 : 32'hFFFF_FFFF;
                @(posedge clk); @(negedge clk);
            end
        end
        #1;
        n_tests++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL wrap_state got=%0d exp=1", state_o); end
        n_tests++; if (retired_o !== cexp(17 % 16)) begin n_fail++; $display("FAIL wrap_retired got=%0d exp=%0d", retired_o, cexp(17 % 16)); end
        n_tests++; if (cycles_o !== cexp(51 % 16)) begin n_fail++; $display("FAIL wrap_cycles got=%0d exp=%0d", cycles_o, cexp(51 % 16)); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_stall();
        test_beq();
        test_back_to_back();
        test_illegal();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
